// File: rtl/column_select_input.sv
// Push-button front end for the Connect-4 game FSM: synchronised, debounced left/right/drop
// buttons steer a wrapping column cursor and commit a move. Optional macro: SKIP_FULL_COL_EN.
module column_select_input #(
    parameter int DB_LIMIT  = 500000,
    parameter int DB_W      = 20,
    parameter int START_COL = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_drop,
    input  logic       accept,
    input  logic       new_game,
    input  logic [6:0] top_row_full,
    output logic [6:0] player_choice,
    output logic       enter,
    output logic [2:0] cursor,
    output logic       drop_blocked
);

    localparam int NB    = 3;
    localparam int LEFT  = 0;
    localparam int RIGHT = 1;
    localparam int DROP  = 2;

    localparam logic [2:0]      START    = 3'(START_COL);
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_LIMIT - 1);

    logic [NB-1:0]   raw;
    logic [NB-1:0]   sync_a;
    logic [NB-1:0]   sync_b;
    logic [NB-1:0]   level;
    logic [NB-1:0]   level_q;
    logic [NB-1:0]   press;
    logic [DB_W-1:0] db_cnt [NB];

    assign raw = {btn_drop, btn_right, btn_left};

    // NOTE: the debounce counters are ordinary flops, not RAM, so the array is cleared in the
    // reset branch like every other register; a held button must then re-qualify from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a  <= '0;
            sync_b  <= '0;
            level   <= '0;
            level_q <= '0;
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values,
            // which keeps the two synchroniser stages from collapsing into one.
            sync_a  <= raw;
            sync_b  <= sync_a;
            level_q <= level;
            for (int i = 0; i < NB; i++) begin
                if (sync_b[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_cnt[i] <= '0;
                    level[i]  <= ~level[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Only the debounced 0->1 transition is an event; releases are ignored.
    assign press = level & ~level_q;

    function automatic logic [2:0] wrap_step(input logic [2:0] col, input logic up);
        if (up) begin
            return (col == 3'd6) ? 3'd0 : col + 3'd1;
        end
        return (col == 3'd0) ? 3'd6 : col - 3'd1;
    endfunction

    function automatic logic [6:0] col_onehot(input logic [2:0] col);
        return 7'b1000000 >> col;
    endfunction

`ifdef SKIP_FULL_COL_EN
    // First non-full column walking away from 'from'; stays on 'from' if all others are full.
    function automatic logic [2:0] seek(input logic [2:0] from, input logic up,
                                        input logic [6:0] full);
        logic [2:0] cand;
        logic [2:0] found;
        logic       hit;
        cand  = from;
        found = from;
        hit   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cand = wrap_step(cand, up);
            if (!hit && !full[cand]) begin
                found = cand;
                hit   = 1'b1;
            end
        end
        return found;
    endfunction
`endif

    logic       move_left;
    logic       move_right;
    logic       here_full;
    logic [2:0] start_target;
    logic [2:0] left_target;
    logic [2:0] right_target;
    logic [2:0] cursor_next;
    logic       enter_next;
    logic       blocked_next;

`ifdef SKIP_FULL_COL_EN
    assign here_full    = top_row_full[cursor];
    assign start_target = top_row_full[START] ? seek(START, 1'b1, top_row_full) : START;
    assign left_target  = seek(cursor, 1'b0, top_row_full);
    assign right_target = seek(cursor, 1'b1, top_row_full);
`else
    logic unused_top_row_full;
    assign unused_top_row_full = ^top_row_full;
    assign here_full    = 1'b0;
    assign start_target = START;
    assign left_target  = wrap_step(cursor, 1'b0);
    assign right_target = wrap_step(cursor, 1'b1);
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        move_left    = press[LEFT] & ~press[RIGHT];
        move_right   = press[RIGHT] & ~press[LEFT];
        cursor_next  = cursor;
        enter_next   = press[DROP] & accept & ~here_full;
        blocked_next = press[DROP] & accept & here_full;
        if (new_game) begin
            cursor_next = start_target;
        end else if (move_left) begin
            cursor_next = left_target;
        end else if (move_right) begin
            cursor_next = right_target;
        end
    end

    // A committed drop reports the column the cursor sat on before this cycle's move.
    always_ff @(posedge clk) begin
        if (reset) begin
            cursor        <= START;
            player_choice <= col_onehot(START);
            enter         <= 1'b0;
            drop_blocked  <= 1'b0;
        end else begin
            cursor        <= cursor_next;
            player_choice <= col_onehot(enter_next ? cursor : cursor_next);
            enter         <= enter_next;
            drop_blocked  <= blocked_next;
        end
    end

endmodule

// File: tb/tb_column_select_input.sv
// Self-checking bench for column_select_input (DB_LIMIT=4): reference model plus directed presses.
module tb_column_select_input;

    localparam int DB_LIMIT  = 4;
    localparam int DB_W      = 4;
    localparam int START_COL = 3;
    localparam int HOLD      = 10;
`ifdef SKIP_FULL_COL_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_drop = 1'b0;
    logic       accept = 1'b0;
    logic       new_game = 1'b0;
    logic [6:0] top_row_full = 7'b0;
    logic [6:0] player_choice;
    logic       enter;
    logic [2:0] cursor;
    logic       drop_blocked;

    column_select_input #(
        .DB_LIMIT (DB_LIMIT),
        .DB_W     (DB_W),
        .START_COL(START_COL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_drop     (btn_drop),
        .accept       (accept),
        .new_game     (new_game),
        .top_row_full (top_row_full),
        .player_choice(player_choice),
        .enter        (enter),
        .cursor       (cursor),
        .drop_blocked (drop_blocked)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_cursor;
    logic [6:0] m_pc;
    bit         m_enter;
    bit         m_blk;
    bit         m_valid = 1'b0;
    bit         m_deb [3];
    bit         m_ev  [3];
    bit         m_raw_q [3][$];
    bit         m_win   [3][$];

    function automatic int seek_model(int c, int dir, logic [6:0] full);
        for (int k = 1; k < 7; k++) begin
            int cand;
            cand = (c + dir * k + 14) % 7;
            if (!full[cand]) return cand;
        end
        return c;
    endfunction

    function automatic int move_model(int c, int dir, logic [6:0] full);
        if (SKIP) return seek_model(c, dir, full);
        return (c + dir + 7) % 7;
    endfunction

    always @(posedge clk) begin
        bit raw [3];
        raw[0] = btn_left;
        raw[1] = btn_right;
        raw[2] = btn_drop;
        if (reset) begin
            m_valid  = 1'b1;
            m_cursor = START_COL;
            m_pc     = 7'b1000000 >> START_COL;
            m_enter  = 1'b0;
            m_blk    = 1'b0;
            for (int b = 0; b < 3; b++) begin
                m_deb[b] = 1'b0;
                m_ev[b]  = 1'b0;
                m_raw_q[b].delete();
                m_win[b].delete();
            end
        end else begin
            int  nc;
            bit  full_here;
            full_here = SKIP && top_row_full[m_cursor];
            nc = m_cursor;
            if (new_game)
                nc = (SKIP && top_row_full[START_COL]) ? seek_model(START_COL, 1, top_row_full)
                                                       : START_COL;
            else if (m_ev[0] && !m_ev[1]) nc = move_model(m_cursor, -1, top_row_full);
            else if (m_ev[1] && !m_ev[0]) nc = move_model(m_cursor, 1, top_row_full);
            m_enter  = m_ev[2] && accept && !full_here;
            m_blk    = m_ev[2] && accept && full_here;
            m_pc     = 7'b1000000 >> (m_enter ? m_cursor : nc);
            m_cursor = nc;
            // Debounce: flip once DB_LIMIT consecutive synced samples differ from the level.
            for (int b = 0; b < 3; b++) begin
                bit synced;
                bit all_diff;
                synced = (m_raw_q[b].size() >= 2) ? m_raw_q[b][m_raw_q[b].size() - 2] : 1'b0;
                m_raw_q[b].push_back(raw[b]);
                if (m_raw_q[b].size() > 2) void'(m_raw_q[b].pop_front());
                m_win[b].push_back(synced);
                if (m_win[b].size() > DB_LIMIT) void'(m_win[b].pop_front());
                all_diff = (m_win[b].size() == DB_LIMIT);
                foreach (m_win[b][k]) if (m_win[b][k] == m_deb[b]) all_diff = 1'b0;
                m_ev[b] = 1'b0;
                if (all_diff) begin
                    m_deb[b] = ~m_deb[b];
                    m_ev[b]  = m_deb[b];
                    m_win[b].delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_cursor", 16'(cursor), 16'(m_cursor));
            check("model_player_choice", 16'(player_choice), 16'(m_pc));
            check("model_enter", 16'(enter), 16'(m_enter));
            check("model_drop_blocked", 16'(drop_blocked), 16'(m_blk));
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [2:0] mask, output int n_enter, output int n_blk,
                         output logic [6:0] pc_seen);
        n_enter = 0;
        n_blk   = 0;
        pc_seen = '0;
        {btn_drop, btn_right, btn_left} = mask;
        for (int ph = 0; ph < 2; ph++) begin
            repeat (HOLD) begin
                @(negedge clk);
                if (enter) begin
                    n_enter++;
                    pc_seen = player_choice;
                end
                if (drop_blocked) n_blk++;
            end
            {btn_drop, btn_right, btn_left} = 3'b000;
        end
    endtask

    task automatic tap(input logic [2:0] mask, input int times);
        int         ne;
        int         nb;
        logic [6:0] pc;
        repeat (times) press(mask, ne, nb, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int         ne;
        int         nb;
        logic [6:0] pc;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_cursor", 16'(cursor), 16'd3);
        check("reset_player_choice", 16'(player_choice), 16'(7'b0001000));
        check("reset_enter", 16'(enter), 16'd0);
        check("reset_drop_blocked", 16'(drop_blocked), 16'd0);

        // Bouncing right button, then a clean hold: exactly one move, 7 cycles after the hold.
        for (int i = 0; i < 10; i++) begin
            btn_right = ((i / 2) % 2 == 1);
            @(negedge clk);
        end
        btn_right = 1'b1;
        repeat (6) @(negedge clk);
        check("bounce_no_early_move", 16'(cursor), 16'd3);
        @(negedge clk);
        check("bounce_move_at_7", 16'(cursor), 16'd4);
        repeat (HOLD) @(negedge clk);
        check("bounce_single_move", 16'(cursor), 16'd4);
        btn_right = 1'b0;
        repeat (HOLD) @(negedge clk);

        // Left wrap from 0 and right wrap from 6.
        tap(3'b001, 4);
        check("walk_to_zero", 16'(cursor), 16'd0);
        tap(3'b001, 1);
        check("left_wrap_cursor", 16'(cursor), 16'd6);
        check("left_wrap_player_choice", 16'(player_choice), 16'(7'b0000001));
        tap(3'b010, 1);
        check("right_wrap_cursor", 16'(cursor), 16'd0);

        // Simultaneous left and right cancel.
        tap(3'b011, 1);
        check("left_right_cancel", 16'(cursor), 16'd0);

        // Drop with accept at cursor 2.
        tap(3'b010, 2);
        accept = 1'b1;
        press(3'b100, ne, nb, pc);
        check("drop_enter_count", 16'(ne), 16'd1);
        check("drop_player_choice", 16'(pc), 16'(7'b0010000));

        // Drop without accept is discarded, not queued.
        accept = 1'b0;
        press(3'b100, ne, nb, pc);
        check("drop_no_accept_enter", 16'(ne), 16'd0);
        accept = 1'b1;
        ne = 0;
        repeat (HOLD) begin
            @(negedge clk);
            if (enter) ne++;
        end
        check("drop_not_queued", 16'(ne), 16'd0);

        // Drop coinciding with new_game at cursor 5.
        tap(3'b010, 3);
        check("at_cursor_5", 16'(cursor), 16'd5);
        btn_drop = 1'b1;
        repeat (6) @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check("newgame_drop_enter", 16'(enter), 16'd1);
        check("newgame_drop_choice", 16'(player_choice), 16'(7'b0000010));
        @(negedge clk);
        check("newgame_cursor", 16'(cursor), 16'd3);
        check("newgame_enter_single", 16'(enter), 16'd0);
        btn_drop = 1'b0;
        repeat (HOLD) @(negedge clk);

        // Reset in the middle of a debounce, button held through it.
        btn_right = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_cursor", 16'(cursor), 16'd3);
        repeat (20) @(negedge clk);
        check("held_through_reset_one_move", 16'(cursor), 16'd4);
        btn_right = 1'b0;
        repeat (HOLD) @(negedge clk);

`ifdef SKIP_FULL_COL_EN
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        tap(3'b001, 2);
        check("skip_at_cursor_1", 16'(cursor), 16'd1);
        top_row_full = 7'b0010100;
        tap(3'b010, 1);
        check("skip_right_past_full", 16'(cursor), 16'd3);
        top_row_full = 7'b0001000;
        press(3'b100, ne, nb, pc);
        check("skip_drop_full_blocked", 16'(nb), 16'd1);
        check("skip_drop_full_no_enter", 16'(ne), 16'd0);
        top_row_full = 7'b0;
        repeat (2) @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
